// File: rtl/spi_mem_bridge.sv
// SPI-style slave fused with a single-port word memory; 2-bit command frames, burst capable.
// Latency: a write lands on the last bit edge; first read bit follows the turnaround edge, i.e. it is driven on the 5th edge.
// Backpressure: none; the host paces everything with SS_n, and deasserting SS_n discards any partial word.
// Ports: clk, rst (async, active high), SS_n (frame select, active low), MOSI (serial in, MSB first),
//        MISO (registered serial out, MSB first), busy (frame in progress).
module spi_mem_bridge #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int AUTO_INC   = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic busy
);

  localparam int SW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW = $clog2(SW + 1);
  localparam logic [CW-1:0]         C_ONE  = CW'(1);
  localparam logic [CW-1:0]         A_LAST = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0]         D_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] A_ONE  = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {IDLE, CMD, WR_ADDR, WR_DATA, RD_ADDR, RD_DATA} state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt;
  logic [SW-2:0]          sh;        // holds the bits before the current one; the last bit comes straight from MOSI
  logic                   cmd_hi;
  logic                   addr_done; // address already loaded in this frame: extra bits are ignored
  logic                   rd_turn;   // next RD_DATA edge is the turnaround that fetches the word
  logic [DATA_WIDTH-1:0]  tx_reg;
  logic [ADDR_WIDTH-1:0]  wr_addr, rd_addr;
  logic [DATA_WIDTH-1:0]  mem [0:(1<<ADDR_WIDTH)-1];

  logic                   addr_last, data_last, wr_en;
  logic [ADDR_WIDTH-1:0]  addr_word;
  logic [DATA_WIDTH-1:0]  data_word;

  assign addr_last = (cnt == A_LAST);
  assign data_last = (cnt == D_LAST);
  assign addr_word = {sh[ADDR_WIDTH-2:0], MOSI};
  assign data_word = {sh[DATA_WIDTH-2:0], MOSI};
  assign wr_en     = !rst && !SS_n && (state == WR_DATA) && data_last;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (SS_n) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: state_nxt = CMD;
        CMD: begin
          if (cnt == C_ONE) begin
            case ({cmd_hi, MOSI})
              2'b00:   state_nxt = WR_ADDR;
              2'b01:   state_nxt = WR_DATA;
              2'b10:   state_nxt = RD_ADDR;
              default: state_nxt = RD_DATA;
            endcase
          end
        end
        default: state_nxt = state;
      endcase
    end
  end

  // Memory array is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= data_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      MISO      <= 1'b0;
      cnt       <= '0;
      sh        <= '0;
      cmd_hi    <= 1'b0;
      addr_done <= 1'b0;
      rd_turn   <= 1'b1;
      tx_reg    <= '0;
      wr_addr   <= '0;
      rd_addr   <= '0;
    end else begin
      MISO <= 1'b0;
      if (SS_n || state == IDLE) begin
        cnt       <= '0;
        addr_done <= 1'b0;
        rd_turn   <= 1'b1;
      end else begin
        case (state)
          CMD: begin
            cmd_hi <= MOSI;
            cnt    <= (cnt == C_ONE) ? '0 : cnt + C_ONE;
          end
          WR_ADDR, RD_ADDR: begin
            if (!addr_done) begin
              sh  <= {sh[SW-3:0], MOSI};
              cnt <= cnt + C_ONE;
              if (addr_last) begin
                addr_done <= 1'b1;
                if (state == WR_ADDR) wr_addr <= addr_word;
                else                  rd_addr <= addr_word;
              end
            end
          end
          WR_DATA: begin
            sh <= {sh[SW-3:0], MOSI};
            if (data_last) begin
              cnt <= '0;
              if (AUTO_INC != 0) wr_addr <= wr_addr + A_ONE;
            end else begin
              cnt <= cnt + C_ONE;
            end
          end
          RD_DATA: begin
            if (rd_turn) begin
              tx_reg  <= mem[rd_addr];
              rd_turn <= 1'b0;
              cnt     <= '0;
            end else begin
              MISO   <= tx_reg[DATA_WIDTH-1];
              tx_reg <= {tx_reg[DATA_WIDTH-2:0], 1'b0};
              if (data_last) begin
                cnt     <= '0;
                rd_turn <= 1'b1;
                if (AUTO_INC != 0) rd_addr <= rd_addr + A_ONE;
              end else begin
                cnt <= cnt + C_ONE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_mem_bridge.sv
module tb_spi_mem_bridge;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic SS_n = 1'b1;
  logic MOSI = 1'b0;
  logic miso0, busy0, miso1, busy1;
  logic sel = 1'b0;
  logic miso_s, busy_s;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] rd_buf  [0:3];
  logic       turn_buf[0:3];

  always #5 clk = ~clk;

  spi_mem_bridge #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .AUTO_INC(1)) dut0 (
    .clk(clk), .rst(rst), .SS_n(SS_n), .MOSI(MOSI), .MISO(miso0), .busy(busy0));
  spi_mem_bridge #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .AUTO_INC(0)) dut1 (
    .clk(clk), .rst(rst), .SS_n(SS_n), .MOSI(MOSI), .MISO(miso1), .busy(busy1));

  assign miso_s = sel ? miso1 : miso0;
  assign busy_s = sel ? busy1 : busy0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      MOSI = v[7-i];
      tick();
    end
  endtask

  task automatic frame_begin(input logic [1:0] cmd);
    SS_n = 1'b0;
    tick();
    MOSI = cmd[1];
    tick();
    MOSI = cmd[0];
    tick();
  endtask

  task automatic frame_end();
    SS_n = 1'b1;
    MOSI = 1'b0;
    tick();
  endtask

  task automatic wr_addr_f(input logic [7:0] a);
    frame_begin(2'b00);
    send_bits(a, 8);
    frame_end();
  endtask

  task automatic rd_addr_f(input logic [7:0] a);
    frame_begin(2'b10);
    send_bits(a, 8);
    frame_end();
  endtask

  task automatic wr_data_f(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2, input int n);
    frame_begin(2'b01);
    if (n > 0) send_bits(w0, 8);
    if (n > 1) send_bits(w1, 8);
    if (n > 2) send_bits(w2, 8);
    frame_end();
  endtask

  // Captures the turnaround bit and the data word for each of n words into turn_buf/rd_buf.
  task automatic rd_data_f(input int n);
    frame_begin(2'b11);
    for (int k = 0; k < n; k++) begin
      tick();
      turn_buf[k] = miso_s;
      for (int i = 0; i < 8; i++) begin
        tick();
        rd_buf[k][7-i] = miso_s;
      end
    end
    frame_end();
  endtask

  task automatic test_reset();
    rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0;
    tick(); tick();
    n_cmp++; if (miso0 !== 1'b0) begin n_bad++; $display("FAIL reset_miso got %b want 0", miso0); end
    n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy0); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_rw();
    sel = 1'b0;
    frame_begin(2'b00);
    n_cmp++; if (busy0 !== 1'b1) begin n_bad++; $display("FAIL t1_busy_in_frame got %b want 1", busy0); end
    send_bits(8'h10, 8);
    frame_end();
    n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL t1_busy_after_frame got %b want 0", busy0); end
    wr_data_f(8'hA5, 8'h00, 8'h00, 1);
    rd_addr_f(8'h10);
    rd_data_f(1);
    n_cmp++; if (turn_buf[0] !== 1'b0) begin n_bad++; $display("FAIL t1_turnaround got %b want 0", turn_buf[0]); end
    n_cmp++; if (rd_buf[0] !== 8'hA5) begin n_bad++; $display("FAIL t1_read got %h want a5", rd_buf[0]); end
  endtask

  task automatic test_burst_wrap();
    logic [7:0] exp [0:2];
    exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
    sel = 1'b0;
    wr_addr_f(8'hFE);
    wr_data_f(8'h11, 8'h22, 8'h33, 3);
    rd_addr_f(8'hFE);
    rd_data_f(3);
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (turn_buf[k] !== 1'b0) begin n_bad++; $display("FAIL t3_turnaround[%0d] got %b want 0", k, turn_buf[k]); end
      n_cmp++; if (rd_buf[k] !== exp[k]) begin n_bad++; $display("FAIL t3_burst[%0d] got %h want %h", k, rd_buf[k], exp[k]); end
    end
  endtask

  task automatic test_abort();
    sel = 1'b0;
    wr_addr_f(8'h40);
    wr_data_f(8'h5A, 8'hC3, 8'h00, 2);
    wr_addr_f(8'h41);
    frame_begin(2'b01);
    send_bits(8'hFF, 5);
    frame_end();
    n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL t4_busy_after_abort got %b want 0", busy0); end
    rd_addr_f(8'h41);
    rd_data_f(1);
    n_cmp++; if (rd_buf[0] !== 8'hC3) begin n_bad++; $display("FAIL t4_target_kept got %h want c3", rd_buf[0]); end
    // wr_addr must still be 0x41 after the aborted word
    wr_data_f(8'h99, 8'h00, 8'h00, 1);
    // trailing bits after a completed address are ignored
    frame_begin(2'b10);
    send_bits(8'h40, 8);
    send_bits(8'hE0, 3);
    frame_end();
    rd_data_f(2);
    n_cmp++; if (rd_buf[0] !== 8'h5A) begin n_bad++; $display("FAIL t4_extra_addr_bits got %h want 5a", rd_buf[0]); end
    n_cmp++; if (rd_buf[1] !== 8'h99) begin n_bad++; $display("FAIL t4_wr_addr_kept got %h want 99", rd_buf[1]); end
  endtask

  task automatic test_reset_mid_read();
    sel = 1'b0;
    rd_addr_f(8'hFE);
    frame_begin(2'b11);
    tick();
    for (int i = 0; i < 4; i++) tick();
    // mem[0xFE] = 0x11: fourth bit is 1
    n_cmp++; if (miso0 !== 1'b1) begin n_bad++; $display("FAIL t5_bit4_before_rst got %b want 1", miso0); end
    rst = 1'b1;
    #1;
    n_cmp++; if (miso0 !== 1'b0) begin n_bad++; $display("FAIL t5_miso_on_rst got %b want 0", miso0); end
    n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL t5_busy_on_rst got %b want 0", busy0); end
    SS_n = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    // both pointers back at 0: write then read without loading addresses
    wr_data_f(8'h3C, 8'h00, 8'h00, 1);
    rd_data_f(1);
    n_cmp++; if (rd_buf[0] !== 8'h3C) begin n_bad++; $display("FAIL t5_addr_zero got %h want 3c", rd_buf[0]); end
    rd_addr_f(8'h10);
    rd_data_f(1);
    n_cmp++; if (rd_buf[0] !== 8'hA5) begin n_bad++; $display("FAIL t5_mem_kept got %h want a5", rd_buf[0]); end
  endtask

  task automatic test_no_inc();
    sel = 1'b1;
    wr_addr_f(8'h06);
    wr_data_f(8'hEE, 8'h00, 8'h00, 1);
    wr_addr_f(8'h05);
    wr_data_f(8'h01, 8'h02, 8'h00, 2);
    rd_addr_f(8'h05);
    rd_data_f(2);
    n_cmp++; if (rd_buf[0] !== 8'h02) begin n_bad++; $display("FAIL t6_word0 got %h want 02", rd_buf[0]); end
    n_cmp++; if (rd_buf[1] !== 8'h02) begin n_bad++; $display("FAIL t6_reread got %h want 02", rd_buf[1]); end
    rd_addr_f(8'h06);
    rd_data_f(1);
    n_cmp++; if (rd_buf[0] !== 8'hEE) begin n_bad++; $display("FAIL t6_next_untouched got %h want ee", rd_buf[0]); end
    n_cmp++; if (busy_s !== 1'b0) begin n_bad++; $display("FAIL t6_busy_idle got %b want 0", busy_s); end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_rw();
    test_burst_wrap();
    test_abort();
    test_reset_mid_read();
    test_no_inc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
